// File: rtl/systolic_sched.sv
// systolic_sched: buffers one k-step wave (A column then B row), issues it to mac_array, drains, streams C out.
// Optional SYSTOLIC_SCHED_PERF_EN adds a saturating job cycle counter on cycles_o.
module systolic_sched #(
  parameter int width_p        = 32,
  parameter int array_width_p  = 2,
  parameter int array_height_p = 2,
  parameter int k_p            = 2,
  parameter int drain_p        = 4
) (
  input  logic                                              clk_i,
  input  logic                                              reset_i,
  input  logic                                              en_i,
  input  logic                                              abort_i,
  input  logic                                              valid_i,
  output logic                                              ready_o,
  input  logic [width_p-1:0]                                data_i,
  output logic [array_height_p*width_p-1:0]                 row_o,
  output logic [array_height_p-1:0]                         row_valid_o,
  input  logic [array_height_p-1:0]                         row_ready_i,
  output logic [array_width_p*width_p-1:0]                  col_o,
  output logic [array_width_p-1:0]                          col_valid_o,
  input  logic [array_width_p-1:0]                          col_ready_i,
  input  logic [array_height_p*array_width_p*width_p-1:0]   z_i,
  output logic                                              array_clear_o,
  output logic                                              valid_o,
  input  logic                                              yumi_i,
  output logic [width_p-1:0]                                data_o
`ifdef SYSTOLIC_SCHED_PERF_EN
  , output logic [31:0]                                     cycles_o
`endif
);
  localparam int h_lp       = array_height_p;
  localparam int w_lp       = array_width_p;
  localparam int n_lp       = h_lp + w_lp;
  localparam int hw_lp      = h_lp * w_lp;
  localparam int word_w_lp  = n_lp > 1 ? $clog2(n_lp) : 1;
  localparam int k_w_lp     = k_p > 1 ? $clog2(k_p) : 1;
  localparam int drain_w_lp = drain_p > 1 ? $clog2(drain_p) : 1;
  localparam int out_w_lp   = hw_lp > 1 ? $clog2(hw_lp) : 1;

  typedef enum logic [2:0] {s_idle, s_load, s_issue, s_drain, s_out, s_clear} state_e;

  state_e                state_r, state_n;
  logic [width_p-1:0]    buf_r [n_lp];
  logic [word_w_lp-1:0]  word_cnt_r;
  logic [k_w_lp-1:0]     k_cnt_r;
  logic [drain_w_lp-1:0] drain_cnt_r;
  logic [out_w_lp-1:0]   out_cnt_r;
  logic [n_lp-1:0]       issued_r, hs;
  logic                  acc, oy, all_issued, last_word, last_k, last_drain, last_out;

  assign ready_o       = state_r == s_idle || state_r == s_load;
  assign valid_o       = state_r == s_out;
  assign array_clear_o = state_r == s_clear;
  assign row_valid_o   = state_r == s_issue ? ~issued_r[h_lp-1:0] : '0;
  assign col_valid_o   = state_r == s_issue ? ~issued_r[n_lp-1:h_lp] : '0;
  assign data_o        = z_i[int'(out_cnt_r)*width_p +: width_p];
  assign hs            = {col_valid_o & col_ready_i, row_valid_o & row_ready_i} & {n_lp{en_i}};
  assign all_issued    = &(issued_r | hs);
  assign acc           = valid_i & ready_o & en_i;
  assign oy            = valid_o & yumi_i & en_i;
  assign last_word     = word_cnt_r == word_w_lp'(n_lp - 1);
  assign last_k        = k_cnt_r == k_w_lp'(k_p - 1);
  assign last_drain    = drain_cnt_r == drain_w_lp'(drain_p - 1);
  assign last_out      = out_cnt_r == out_w_lp'(hw_lp - 1);

  for (genvar r = 0; r < h_lp; r++) assign row_o[r*width_p +: width_p] = buf_r[r];
  for (genvar c = 0; c < w_lp; c++) assign col_o[c*width_p +: width_p] = buf_r[h_lp+c];

  always_comb begin
    state_n = state_r;
    case (state_r)
      s_idle:  state_n = acc ? s_load : s_idle;
      s_load:  state_n = acc && last_word ? s_issue : s_load;
      s_issue: state_n = !all_issued ? s_issue : last_k ? s_drain : s_load;
      s_drain: state_n = last_drain ? s_out : s_drain;
      s_out:   state_n = oy && last_out ? s_clear : s_out;
      default: state_n = s_idle;
    endcase
    // CLEAR is already returning the array to a clean state, so abort there adds nothing
    if (abort_i && state_r != s_idle && state_r != s_clear) state_n = s_clear;
  end

  always_ff @(posedge clk_i)
    if (reset_i || (en_i && state_n == s_clear)) begin
      state_r     <= reset_i ? s_idle : s_clear;
      word_cnt_r  <= '0;
      k_cnt_r     <= '0;
      drain_cnt_r <= '0;
      out_cnt_r   <= '0;
      issued_r    <= '0;
      for (int i = 0; i < n_lp; i++) buf_r[i] <= '0;
    end else if (en_i) begin
      state_r <= state_n;
      if (acc) begin
        buf_r[word_cnt_r] <= data_i;
        word_cnt_r        <= last_word ? '0 : word_cnt_r + 1'b1;
      end
      if (state_r == s_issue) begin
        issued_r <= all_issued ? '0 : issued_r | hs;
        if (all_issued) k_cnt_r <= last_k ? '0 : k_cnt_r + 1'b1;
      end
      if (state_r == s_drain) drain_cnt_r <= last_drain ? '0 : drain_cnt_r + 1'b1;
      if (oy) out_cnt_r <= out_cnt_r + 1'b1;
    end

`ifdef SYSTOLIC_SCHED_PERF_EN
  always_ff @(posedge clk_i)
    if (reset_i) cycles_o <= '0;
    else if (en_i) cycles_o <= state_r == s_clear ? '0 :
                               (state_r != s_idle && ~&cycles_o) ? cycles_o + 1'b1 : cycles_o;
`endif
endmodule

// File: tb/tb_systolic_sched.sv
// tb_systolic_sched: scoreboard bench with an ideal mac_array model driving z_i.
// Honours SYSTOLIC_SCHED_PERF_EN to also check cycles_o.
module tb_systolic_sched;
  localparam int H = 2, W = 2, K = 2, D = 4, DW = 32;
  localparam int base_lat = K * (H + W + 1) + D;

  logic clk = 1'b0;
  logic reset_i, en_i, abort_i, valid_i, ready_o, array_clear_o, valid_o, yumi_i;
  logic [DW-1:0] data_i, data_o;
  logic [H*DW-1:0] row_o;
  logic [H-1:0] row_valid_o, row_ready_i;
  logic [W*DW-1:0] col_o;
  logic [W-1:0] col_valid_o, col_ready_i;
  logic [H*W*DW-1:0] z_i;
`ifdef SYSTOLIC_SCHED_PERF_EN
  logic [31:0] cycles_o, perf_out;
`endif

  systolic_sched #(.width_p(DW), .array_width_p(W), .array_height_p(H), .k_p(K), .drain_p(D)) dut (
    .clk_i(clk), .reset_i(reset_i), .en_i(en_i), .abort_i(abort_i),
    .valid_i(valid_i), .ready_o(ready_o), .data_i(data_i),
    .row_o(row_o), .row_valid_o(row_valid_o), .row_ready_i(row_ready_i),
    .col_o(col_o), .col_valid_o(col_valid_o), .col_ready_i(col_ready_i),
    .z_i(z_i), .array_clear_o(array_clear_o), .valid_o(valid_o), .yumi_i(yumi_i), .data_o(data_o)
`ifdef SYSTOLIC_SCHED_PERF_EN
    , .cycles_o(cycles_o)
`endif
  );

  always #5 clk = ~clk;

  int n_chk = 0, n_pass = 0, cyc = 0, t_acc = 0, t_val = 0, clr_cnt = 0, row_hs_cnt = 0, acc_n = 0;
  bit job_active = 0, seen_val = 0, yumi_en = 1;
  logic [DW-1:0] in_q[$], exp_q[$];
  logic [DW-1:0] cm [H*W];
  logic [DW-1:0] a_v [H];
  logic [DW-1:0] b_v [W];
  logic [H-1:0] a_got, m_hr;
  logic [W-1:0] b_got, m_hc;
  logic m_acc, m_oy, m_clr;
  logic [DW-1:0] am [H][K];
  logic [DW-1:0] bm [K][W];

  always_comb begin
    z_i = '0;
    for (int i = 0; i < H*W; i++) z_i[i*DW +: DW] = cm[i];
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
  endtask

  // Ideal array: a wave contributes A[:,k]*B[k,:] once every row and column port has handshaken.
  initial begin
    foreach (cm[i]) cm[i] = '0;
    a_got = '0;
    b_got = '0;
    forever begin
      @(negedge clk);
      #1;
      m_acc = valid_i && ready_o && en_i && !reset_i;
      m_hr  = reset_i ? '0 : row_valid_o & row_ready_i & {H{en_i}};
      m_hc  = reset_i ? '0 : col_valid_o & col_ready_i & {W{en_i}};
      m_oy  = valid_o && yumi_i && en_i && !reset_i;
      m_clr = array_clear_o && !reset_i;
      if (m_oy) begin
        if (exp_q.size() > 0) check("result", data_o, exp_q.pop_front());
        else check("unexpected_result", data_o, 'x);
      end
      if (m_acc && !job_active) t_acc = cyc;
      if (valid_o && !seen_val) begin
        seen_val = 1;
        t_val = cyc;
`ifdef SYSTOLIC_SCHED_PERF_EN
        perf_out = cycles_o;
`endif
      end
      for (int r = 0; r < H; r++) if (m_hr[r]) begin a_v[r] = row_o[r*DW +: DW]; a_got[r] = 1'b1; end
      for (int c = 0; c < W; c++) if (m_hc[c]) begin b_v[c] = col_o[c*DW +: DW]; b_got[c] = 1'b1; end
      @(posedge clk);
      cyc++;
      if (reset_i) begin
        foreach (cm[i]) cm[i] = '0;
        a_got = '0;
        b_got = '0;
        job_active = 0;
      end else begin
        if (m_acc) begin
          void'(in_q.pop_front());
          if (!job_active) begin job_active = 1; seen_val = 0; acc_n = 0; end
          acc_n++;
        end
        row_hs_cnt += $countones(m_hr);
        if (&a_got && &b_got) begin
          for (int r = 0; r < H; r++)
            for (int c = 0; c < W; c++) cm[r*W+c] = cm[r*W+c] + a_v[r] * b_v[c];
          a_got = '0;
          b_got = '0;
        end
        if (m_clr) begin
          foreach (cm[i]) cm[i] = '0;
          a_got = '0;
          b_got = '0;
          clr_cnt++;
          job_active = 0;
        end
      end
    end
  end

  initial begin
    valid_i = 0;
    data_i  = '0;
    yumi_i  = 0;
    forever begin
      @(negedge clk);
      valid_i = in_q.size() > 0;
      data_i  = in_q.size() > 0 ? in_q[0] : '0;
      yumi_i  = yumi_en && valid_o;
    end
  end

  task automatic set_basic();
    am = '{'{1, 2}, '{3, 4}};
    bm = '{'{5, 6}, '{7, 8}};
  endtask

  task automatic set_rand();
    for (int r = 0; r < H; r++) for (int k = 0; k < K; k++) am[r][k] = $urandom_range(0, 999);
    for (int k = 0; k < K; k++) for (int c = 0; c < W; c++) bm[k][c] = $urandom_range(0, 999);
  endtask

  task automatic push_job();
    logic [DW-1:0] s;
    for (int k = 0; k < K; k++) begin
      for (int r = 0; r < H; r++) in_q.push_back(am[r][k]);
      for (int c = 0; c < W; c++) in_q.push_back(bm[k][c]);
    end
    for (int r = 0; r < H; r++)
      for (int c = 0; c < W; c++) begin
        s = '0;
        for (int k = 0; k < K; k++) s = s + am[r][k] * bm[k][c];
        exp_q.push_back(s);
      end
  endtask

  task automatic wait_done(input string tag);
    int c0 = clr_cnt;
    for (int i = 0; i < 300 && clr_cnt == c0; i++) @(negedge clk);
    check({tag, "_done"}, clr_cnt, c0 + 1);
    repeat (2) @(negedge clk);
    check({tag, "_one_pulse"}, clr_cnt, c0 + 1);
    check({tag, "_drained"}, exp_q.size(), 0);
  endtask

  task automatic wait_rows(input bit nz, input string tag);
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if ((row_valid_o != 0) == nz) break;
    end
    check({tag, "_rows"}, row_valid_o != 0, nz);
  endtask

  initial begin
    int c0, h0;
    reset_i = 1; en_i = 1; abort_i = 0; row_ready_i = '1; col_ready_i = '1;
    repeat (3) @(negedge clk);
    check("rst_ready", ready_o, 1);
    check("rst_valid", valid_o, 0);
    check("rst_row_valid", row_valid_o, 0);
    check("rst_col_valid", col_valid_o, 0);
    check("rst_clear", array_clear_o, 0);
`ifdef SYSTOLIC_SCHED_PERF_EN
    check("rst_cycles", cycles_o, 0);
`endif
    reset_i = 0;

    set_basic();
    push_job();
    wait_done("basic");
    check("basic_latency", t_val - t_acc, base_lat);
`ifdef SYSTOLIC_SCHED_PERF_EN
    check("basic_cycles", perf_out, base_lat - 1);
`endif
    check("basic_idle_ready", ready_o, 1);

    h0 = row_hs_cnt;
    col_ready_i = 2'b01;
    set_basic();
    push_job();
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (col_valid_o[1]) break;
    end
    check("stall_seen", col_valid_o[1], 1);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("stall_col_valid", col_valid_o[1], 1);
      check("stall_col_data", col_o[DW +: DW], 6);
      check("stall_row_valid", row_valid_o, 0);
      check("stall_ready", ready_o, 0);
    end
    col_ready_i = '1;
    wait_done("stall");
    check("stall_row_issues", row_hs_cnt - h0, H * K);

    yumi_en = 0;
    set_basic();
    push_job();
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (valid_o) break;
    end
    check("hold_seen", valid_o, 1);
    for (int i = 0; i < 10; i++) begin
      check("hold_valid", valid_o, 1);
      check("hold_data", data_o, 19);
      @(negedge clk);
    end
    yumi_en = 1;
    wait_done("hold");

    c0 = clr_cnt;
    in_q.push_back(11); in_q.push_back(12); in_q.push_back(13);
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (job_active && acc_n == 3) break;
    end
    check("abort_loaded", acc_n, 3);
    abort_i = 1;
    @(negedge clk);
    abort_i = 0;
    #2;
    check("abort_clear", array_clear_o, 1);
    check("abort_ready_low", ready_o, 0);
    @(negedge clk);
    #2;
    check("abort_clear_end", array_clear_o, 0);
    check("abort_idle_ready", ready_o, 1);
    check("abort_pulses", clr_cnt - c0, 1);
    set_rand();
    push_job();
    wait_done("after_abort");

    set_basic();
    push_job();
    wait_rows(1, "frz_iss_enter");
    en_i = 0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("frz_iss_rows", row_valid_o, 2'b11);
      check("frz_iss_ready", ready_o, 0);
    end
    en_i = 1;
    wait_done("frz_iss");
    check("frz_iss_latency", t_val - t_acc, base_lat + 3);

    set_basic();
    push_job();
    wait_rows(1, "frz_drn_w0");
    wait_rows(0, "frz_drn_l1");
    wait_rows(1, "frz_drn_w1");
    wait_rows(0, "frz_drn_enter");
    en_i = 0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("frz_drn_valid", valid_o, 0);
    end
    en_i = 1;
    wait_done("frz_drn");
    check("frz_drn_latency", t_val - t_acc, base_lat + 3);

    set_rand();
    push_job();
    wait_rows(1, "midrst_enter");
    c0 = clr_cnt;
    reset_i = 1;
    in_q.delete();
    exp_q.delete();
    @(negedge clk);
    #2;
    check("midrst_ready", ready_o, 1);
    check("midrst_valid", valid_o, 0);
    check("midrst_row_valid", row_valid_o, 0);
    check("midrst_col_valid", col_valid_o, 0);
    check("midrst_clear", array_clear_o, 0);
`ifdef SYSTOLIC_SCHED_PERF_EN
    check("midrst_cycles", cycles_o, 0);
`endif
    @(negedge clk);
    reset_i = 0;
    check("midrst_no_pulse", clr_cnt, c0);
    set_basic();
    push_job();
    wait_done("post_rst");

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: bench did not reach its summary, got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end
endmodule
